mips_run_ctrl: RTL and testbench

Synthesizable run controller for the pipelined MIPS core, replacing fixed-delay bench reset sequencing.
- Reset hold: stretches the core's reset for a parametrised number of cycles, then releases the core.
- Run monitoring: counts run cycles, stops on an explicit halt request or a jump-to-self loop, and flags a cycle-budget timeout.
- Placement: sits between the top-level clk/reset and the core's reset/enable inputs; results are exposed to the bench or a debug port.

---
 rtl/mips_run_ctrl_if.sv | 25 ++
 rtl/mips_run_ctrl.sv | 99 +++++++++
 tb/tb_mips_run_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - core-side and status signals of the MIPS run controller
interface mips_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             halt_req;
    logic [PC_W-1:0]  pc;
    logic             pc_valid;
    logic             cpu_reset;
    logic             cpu_en;
    logic [1:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic             timeout;

    modport master (
        output halt_req, pc, pc_valid,
        input  cpu_reset, cpu_en, state, cycle_count, done, timeout
    );

    modport slave (
        input  halt_req, pc, pc_valid,
        output cpu_reset, cpu_en, state, cycle_count, done, timeout
    );
endinterface

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - reset stretcher and run monitor (halt, self-loop, timeout) for the MIPS core
module mips_run_ctrl #(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 100000,
    parameter int HALT_REPEAT  = 3,
    parameter int CNT_W        = 32,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            reset,
    mips_run_ctrl_if.slave  bus
);
    localparam int HW = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam int SW = (HALT_REPEAT < 2) ? 1 : $clog2(HALT_REPEAT + 1);
    localparam logic [HW-1:0]    HOLD_TGT   = HW'(RESET_CYCLES);
    localparam logic [SW-1:0]    SAME_TGT   = SW'(HALT_REPEAT - 1);
    localparam logic [CNT_W-1:0] BUDGET_TGT = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t           st;
    logic             cpu_reset_q;
    logic             cpu_en_q;
    logic [CNT_W-1:0] cycle_count_q;
    logic             done_q;
    logic             timeout_q;
    logic [HW-1:0]    hold_cnt;
    logic [SW-1:0]    same_cnt;
    logic             last_valid;
    logic [PC_W-1:0]  last_pc;

    logic pc_same;
    logic halt_hit;
    logic budget_hit;

    // A stalled cycle (pc_valid=0) neither breaks nor advances a self-loop run.
    assign pc_same    = bus.pc_valid && last_valid && (bus.pc == last_pc);
    assign halt_hit   = bus.halt_req || (pc_same && (same_cnt == SAME_TGT));
    assign budget_hit = (cycle_count_q == BUDGET_TGT);

    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= S_HOLD;
            cpu_reset_q   <= 1'b1;
            cpu_en_q      <= 1'b0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt      <= '0;
            same_cnt      <= '0;
            last_valid    <= 1'b0;
            last_pc       <= '0;
        end else begin
            case (st)
                S_HOLD: begin
                    if (hold_cnt == HOLD_TGT) begin
                        st          <= S_RUN;
                        cpu_reset_q <= 1'b0;
                        cpu_en_q    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_q + CNT_W'(1);
                    if (bus.pc_valid) begin
                        same_cnt   <= pc_same ? same_cnt + SW'(1) : '0;
                        last_pc    <= bus.pc;
                        last_valid <= 1'b1;
                    end
                    // Halt has priority over an expiring budget in the same cycle.
                    if (halt_hit) begin
                        st       <= S_DONE;
                        done_q   <= 1'b1;
                        cpu_en_q <= 1'b0;
                    end else if (budget_hit) begin
                        st        <= S_TIMEOUT;
                        timeout_q <= 1'b1;
                        cpu_en_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cpu_reset   = cpu_reset_q;
    assign bus.cpu_en      = cpu_en_q;
    assign bus.state       = st;
    assign bus.cycle_count = cycle_count_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - directed self-checking bench for mips_run_ctrl
module tb_mips_run_ctrl;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_z;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus_a ();
    mips_run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus_z ();

    mips_run_ctrl #(
        .RESET_CYCLES(4), .MAX_CYCLES(16), .HALT_REPEAT(3), .CNT_W(32), .PC_W(32)
    ) dut_a (
        .clk(clk), .reset(reset_a), .bus(bus_a)
    );

    mips_run_ctrl #(
        .RESET_CYCLES(0), .MAX_CYCLES(16), .HALT_REPEAT(3), .CNT_W(32), .PC_W(32)
    ) dut_z (
        .clk(clk), .reset(reset_z), .bus(bus_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".state"},     32'(bus_a.state), 0);
        check({tag, ".cpu_reset"}, 32'(bus_a.cpu_reset), 1);
        check({tag, ".cpu_en"},    32'(bus_a.cpu_en), 0);
        check({tag, ".count"},     bus_a.cycle_count, 0);
        check({tag, ".done"},      32'(bus_a.done), 0);
        check({tag, ".timeout"},   32'(bus_a.timeout), 0);
    endtask

    // Release reset and verify the 4-edge hold followed by RUN entry.
    task automatic release_and_hold(input string tag);
        reset_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("%s.hold%0d.cpu_reset", tag, k), 32'(bus_a.cpu_reset), 1);
            check($sformatf("%s.hold%0d.state", tag, k), 32'(bus_a.state), 0);
        end
        tick();
        check({tag, ".run.cpu_reset"}, 32'(bus_a.cpu_reset), 0);
        check({tag, ".run.cpu_en"},    32'(bus_a.cpu_en), 1);
        check({tag, ".run.state"},     32'(bus_a.state), 1);
        check({tag, ".run.count"},     bus_a.cycle_count, 0);
    endtask

    task automatic run_start();
        bus_a.halt_req = 1'b0;
        bus_a.pc_valid = 1'b0;
        bus_a.pc       = '0;
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        ticks(5);
    endtask

    task automatic feed_pcs(input string tag, input logic [31:0] seq[], input logic vld[],
                            input int done_at);
        for (int i = 0; i < seq.size(); i++) begin
            bus_a.pc       = seq[i];
            bus_a.pc_valid = vld[i];
            tick();
            check($sformatf("%s.s%0d.state", tag, i + 1), 32'(bus_a.state),
                  (done_at != 0 && i + 1 >= done_at) ? 2 : 1);
        end
        bus_a.pc_valid = 1'b0;
    endtask

    initial begin
        bus_a.halt_req = 1'b0;
        bus_a.pc       = '0;
        bus_a.pc_valid = 1'b0;
        bus_z.halt_req = 1'b0;
        bus_z.pc       = '0;
        bus_z.pc_valid = 1'b0;
        reset_a = 1'b1;
        reset_z = 1'b1;

        // Reset release with a 4-cycle hold
        ticks(3);
        check_reset_state("rst");
        release_and_hold("t1");

        // Explicit halt at cycle_count=10
        ticks(10);
        check("t2.pre.count", bus_a.cycle_count, 10);
        bus_a.halt_req = 1'b1;
        tick();
        bus_a.halt_req = 1'b0;
        check("t2.state",  32'(bus_a.state), 2);
        check("t2.done",   32'(bus_a.done), 1);
        check("t2.cpu_en", 32'(bus_a.cpu_en), 0);
        check("t2.count",  bus_a.cycle_count, 11);
        bus_a.halt_req = 1'b1;
        ticks(20);
        bus_a.halt_req = 1'b0;
        check("t2.frozen.count", bus_a.cycle_count, 11);
        check("t2.frozen.done",  32'(bus_a.done), 1);
        check("t2.frozen.state", 32'(bus_a.state), 2);
        check("t2.frozen.timeout", 32'(bus_a.timeout), 0);

        // Self-loop detection
        run_start();
        feed_pcs("t3a", '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008},
                 '{1, 1, 1, 1, 1, 1}, 6);
        check("t3a.done",  32'(bus_a.done), 1);
        check("t3a.count", bus_a.cycle_count, 6);

        run_start();
        feed_pcs("t3b", '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008, 32'h3008},
                 '{1, 1, 1, 1, 0, 1, 1}, 7);
        check("t3b.count", bus_a.cycle_count, 7);

        run_start();
        feed_pcs("t3c", '{32'h3008, 32'h3008, 32'h300c, 32'h3008, 32'h3008},
                 '{1, 1, 1, 1, 1}, 0);
        check("t3c.done", 32'(bus_a.done), 0);

        // Budget timeout, then reset while in TIMEOUT
        run_start();
        ticks(15);
        check("t4.pre.state", 32'(bus_a.state), 1);
        check("t4.pre.count", bus_a.cycle_count, 15);
        tick();
        check("t4.state",   32'(bus_a.state), 3);
        check("t4.timeout", 32'(bus_a.timeout), 1);
        check("t4.done",    32'(bus_a.done), 0);
        check("t4.cpu_en",  32'(bus_a.cpu_en), 0);
        check("t4.count",   bus_a.cycle_count, 16);
        ticks(3);
        check("t4.frozen.count", bus_a.cycle_count, 16);
        reset_a = 1'b1;
        tick();
        check_reset_state("t5b");
        release_and_hold("t5b");

        // Halt and budget expiring together: DONE wins
        run_start();
        ticks(15);
        bus_a.halt_req = 1'b1;
        tick();
        bus_a.halt_req = 1'b0;
        check("t4tie.state",   32'(bus_a.state), 2);
        check("t4tie.done",    32'(bus_a.done), 1);
        check("t4tie.timeout", 32'(bus_a.timeout), 0);
        check("t4tie.count",   bus_a.cycle_count, 16);

        // Reset mid-run
        run_start();
        ticks(7);
        check("t5a.pre.count", bus_a.cycle_count, 7);
        reset_a = 1'b1;
        tick();
        check_reset_state("t5a");
        release_and_hold("t5a");

        // Zero-cycle hold on the second instance
        check("t6.rst.cpu_reset", 32'(bus_z.cpu_reset), 1);
        check("t6.rst.state",     32'(bus_z.state), 0);
        check("t6.rst.cpu_en",    32'(bus_z.cpu_en), 0);
        reset_z = 1'b0;
        tick();
        check("t6.cpu_en",    32'(bus_z.cpu_en), 1);
        check("t6.state",     32'(bus_z.state), 1);
        check("t6.cpu_reset", 32'(bus_z.cpu_reset), 0);
        tick();
        check("t6.count", bus_z.cycle_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
